// File: rtl/mips_hilo_pkg.sv
// Shared types and defaults for the HI/LO multiply/divide sequencer.
package mips_hilo_pkg;

    localparam int          DEF_DATA_W  = 32;
    localparam logic [31:0] DEF_DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } hilo_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX
    } hilo_state_t;

endpackage

// File: rtl/mips_hilo_sequencer_if.sv
// Pipeline <-> HI/LO sequencer request/response bundle.
interface mips_hilo_sequencer_if
    import mips_hilo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic              op_valid;
    logic              op_ready;
    hilo_op_t          op_code;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              cancel;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

    modport master (
        output op_valid, op_code, src_a, src_b, cancel,
        input  op_ready, rd_data, rd_valid, busy, hi_out, lo_out
    );

    modport slave (
        input  op_valid, op_code, src_a, src_b, cancel,
        output op_ready, rd_data, rd_valid, busy, hi_out, lo_out
    );
endinterface

// File: rtl/mips_muldiv_step.sv
// One iteration of the bit-serial datapath: shift-add multiply or
// restoring divide on a {hi_half, lo_half} accumulator.
module mips_muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic                is_div,
    input  logic [DATA_W-1:0]   m,      // multiplicand or divisor magnitude
    input  logic [2*DATA_W-1:0] acc_i,
    output logic [2*DATA_W-1:0] acc_o
);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] ext;
    logic [DATA_W:0] diff;

    // Mul: add m to the upper half when the multiplier LSB is set, then shift right.
    // Div: shift {rem,quot} left, keep the trial subtraction when it does not go negative.
    always_comb begin
        sum  = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + {1'b0, m & {DATA_W{acc_i[0]}}};
        ext  = acc_i[2*DATA_W-1:DATA_W-1];
        diff = ext - {1'b0, m};
        if (!is_div)
            acc_o = {sum, acc_i[DATA_W-1:1]};
        else if (ext >= {1'b0, m})
            acc_o = {diff[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b1};
        else
            acc_o = {ext[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b0};
    end
endmodule

// File: rtl/mips_hilo_sequencer.sv
// HI/LO owner: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO/MFHI/MFLO.
module mips_hilo_sequencer
    import mips_hilo_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0] DIV0_LO = DATA_W'(DEF_DIV0_LO)
) (
    input logic                  clk,
    input logic                  rst_n,
    mips_hilo_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    hilo_state_t         state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, m_q, m_d;
    logic [2*DATA_W-1:0] acc_q, acc_d, acc_step;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_div_q, is_div_d, is_sgn_q, is_sgn_d;
    logic                neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

    logic                idle, accept, a_neg, b_neg;
    logic [DATA_W-1:0]   abs_a, abs_b, quot, rem;
    logic [2*DATA_W-1:0] prod;

    assign idle   = (state_q == S_IDLE);
    // cancel beats a simultaneous request
    assign accept = bus.op_valid & idle & ~bus.cancel;

    assign bus.op_ready = idle;
    assign bus.busy     = ~idle;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;

    mips_muldiv_step #(.DATA_W(DATA_W)) u_step (
        .is_div (is_div_q),
        .m      (m_q),
        .acc_i  (acc_q),
        .acc_o  (acc_step)
    );

    // Sign handling around the unsigned core
    always_comb begin
        a_neg = is_sgn_q & a_q[DATA_W-1];
        b_neg = is_sgn_q & b_q[DATA_W-1];
        abs_a = a_neg ? -a_q : a_q;
        abs_b = b_neg ? -b_q : b_q;
        quot  = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem   = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        prod  = neg_res_q ? -acc_q : acc_q;
    end

    // Next-state, datapath and HI/LO update
    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        a_d        = a_q;
        b_d        = b_q;
        m_d        = m_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        is_sgn_d   = is_sgn_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        case (state_q)
            S_IDLE: if (accept) begin
                case (bus.op_code)
                    OP_MTHI: hi_d = bus.src_a;
                    OP_MTLO: lo_d = bus.src_a;
                    OP_MFHI: begin rd_data_d = hi_q; rd_valid_d = 1'b1; end
                    OP_MFLO: begin rd_data_d = lo_q; rd_valid_d = 1'b1; end
                    default: begin
                        a_d      = bus.src_a;
                        b_d      = bus.src_b;
                        is_div_d = (bus.op_code == OP_DIV) || (bus.op_code == OP_DIVU);
                        is_sgn_d = (bus.op_code == OP_MULT) || (bus.op_code == OP_DIV);
                        state_d  = S_PREP;
                    end
                endcase
            end
            S_PREP: begin
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                if (is_div_q && (b_q == '0)) begin
                    // divide by zero: HI keeps the raw dividend
                    hi_d    = a_q;
                    lo_d    = DIV0_LO;
                    state_d = S_IDLE;
                end else begin
                    m_d     = is_div_q ? abs_b : abs_a;
                    acc_d   = {{DATA_W{1'b0}}, (is_div_q ? abs_a : abs_b)};
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quot;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // flush aborts any in-flight op without touching HI/LO
        if (bus.cancel && !idle) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            is_sgn_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            m_q        <= m_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            is_sgn_q   <= is_sgn_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
        end
    end
endmodule

// File: tb/tb_mips_hilo_sequencer.sv
// Scoreboard bench for mips_hilo_sequencer.
module tb_mips_hilo_sequencer;
    import mips_hilo_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    logic [63:0] hl_q[$];   // expected {HI,LO} after each mul/div
    logic [31:0] rd_q[$];   // expected rd_data for each MF*
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    mips_hilo_sequencer_if #(.DATA_W(32)) bus ();
    mips_hilo_sequencer #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request until it transfers; returns one cycle after the accept edge.
    task automatic send(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (bus.op_ready !== 1'b1 && n < 100) begin step(); n++; end
        checks++;
        if (bus.op_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready got=%b want=1", bus.op_ready);
        end
        bus.op_valid = 1'b1; bus.op_code = op; bus.src_a = a; bus.src_b = b;
        step();
        bus.op_valid = 1'b0;
    endtask

    task automatic mt(input hilo_op_t op, input logic [31:0] v);
        send(op, v, 32'h0);
        if (op == OP_MTHI) model_hi = v; else model_lo = v;
        checks++;
        if ({bus.hi_out, bus.lo_out} !== {model_hi, model_lo}) begin
            failures++;
            $display("FAIL mt_write got=%h_%h want=%h_%h", bus.hi_out, bus.lo_out, model_hi, model_lo);
        end
    endtask

    task automatic mf(input hilo_op_t op);
        logic [31:0] exp;
        rd_q.push_back(op == OP_MFHI ? model_hi : model_lo);
        send(op, 32'h0, 32'h0);
        checks++;
        if (bus.rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL mf_valid got=%b want=1", bus.rd_valid);
        end
        exp = rd_q.pop_front();
        checks++;
        if (bus.rd_data !== exp) begin
            failures++;
            $display("FAIL mf_data got=%h want=%h", bus.rd_data, exp);
        end
        step();
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL mf_pulse got=%b want=0", bus.rd_valid);
        end
    endtask

    task automatic run_muldiv(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] ehi, input logic [31:0] elo, input int lat);
        int n = 0;
        bit held = 1'b1;
        logic [63:0] exp;
        hl_q.push_back({ehi, elo});
        send(op, a, b);
        while (bus.busy === 1'b1 && n < 200) begin
            if (bus.hi_out !== model_hi || bus.lo_out !== model_lo || bus.op_ready !== 1'b0) held = 1'b0;
            n++;
            step();
        end
        checks++;
        if (n != lat) begin
            failures++;
            $display("FAIL busy_cycles op=%s got=%0d want=%0d", op.name(), n, lat);
        end
        checks++;
        if (!held) begin
            failures++;
            $display("FAIL hold_while_busy op=%s got=changed want=unchanged", op.name());
        end
        exp = hl_q.pop_front();
        checks++;
        if ({bus.hi_out, bus.lo_out} !== exp || bus.op_ready !== 1'b1) begin
            failures++;
            $display("FAIL result op=%s a=%h b=%h got=%h_%h rdy=%b want=%h rdy=1",
                     op.name(), a, b, bus.hi_out, bus.lo_out, bus.op_ready, exp);
        end
        {model_hi, model_lo} = exp;
    endtask

    task automatic test_reset();
        step();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.op_ready, bus.busy, bus.rd_valid} !== 3'b100 || bus.hi_out !== 32'h0 ||
            bus.lo_out !== 32'h0 || bus.rd_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_state rdy/busy/vld=%b%b%b hi=%h lo=%h rd=%h want 100/0/0/0",
                     bus.op_ready, bus.busy, bus.rd_valid, bus.hi_out, bus.lo_out, bus.rd_data);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.op_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release rdy=%b busy=%b want 1/0", bus.op_ready, bus.busy);
        end
    endtask

    task automatic test_mt_mf();
        mt(OP_MTHI, 32'h1234);
        mt(OP_MTLO, 32'hABCD);
        mf(OP_MFHI);
        mf(OP_MFLO);
    endtask

    task automatic test_mul();
        run_muldiv(OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
        run_muldiv(OP_MULTU, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 34);
        run_muldiv(OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 34);
        mf(OP_MFLO);
    endtask

    task automatic test_div();
        run_muldiv(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        run_muldiv(OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        34);
        run_muldiv(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 34);
        run_muldiv(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34);
        run_muldiv(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32'd1,         34);
    endtask

    task automatic test_div0();
        run_muldiv(OP_DIV,  32'd5,         32'd0, 32'd5,         32'hFFFF_FFFF, 1);
        run_muldiv(OP_DIVU, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
    endtask

    task automatic test_hazard();
        int n = 0;
        logic [63:0] exp;
        logic [31:0] erd;
        hl_q.push_back({32'd3, 32'd0});
        send(OP_MULTU, 32'h0001_0000, 32'h0003_0000);
        bus.op_valid = 1'b1; bus.op_code = OP_MFHI;
        while (bus.op_ready !== 1'b1 && n < 200) begin n++; step(); end
        checks++;
        if (n != 34) begin
            failures++;
            $display("FAIL hazard_stall got=%0d want=34", n);
        end
        exp = hl_q.pop_front();
        checks++;
        if ({bus.hi_out, bus.lo_out} !== exp) begin
            failures++;
            $display("FAIL hazard_hilo got=%h_%h want=%h", bus.hi_out, bus.lo_out, exp);
        end
        {model_hi, model_lo} = exp;
        rd_q.push_back(model_hi);
        step();
        bus.op_valid = 1'b0;
        erd = rd_q.pop_front();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== erd) begin
            failures++;
            $display("FAIL hazard_mfhi vld=%b data=%h want 1/%h", bus.rd_valid, bus.rd_data, erd);
        end
    endtask

    task automatic test_cancel();
        mt(OP_MTHI, 32'hAAAA_0001);
        mt(OP_MTLO, 32'h5555_0002);
        send(OP_MULT, 32'd3, 32'd4);
        for (int i = 0; i < 11; i++) step();   // now in CALC, cnt=10
        bus.cancel = 1'b1;
        step();
        bus.cancel = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.op_ready !== 1'b1 ||
            {bus.hi_out, bus.lo_out} !== {model_hi, model_lo}) begin
            failures++;
            $display("FAIL cancel_calc busy=%b rdy=%b hilo=%h_%h want 0/1/%h_%h",
                     bus.busy, bus.op_ready, bus.hi_out, bus.lo_out, model_hi, model_lo);
        end
        // cancel in IDLE swallows the request
        bus.cancel = 1'b1;
        bus.op_valid = 1'b1; bus.op_code = OP_MTHI; bus.src_a = 32'hDEAD_BEEF;
        step();
        bus.op_code = OP_MFLO;
        step();
        checks++;
        if (bus.hi_out !== model_hi || bus.rd_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL cancel_idle hi=%h vld=%b busy=%b want %h/0/0",
                     bus.hi_out, bus.rd_valid, bus.busy, model_hi);
        end
        bus.op_valid = 1'b0;
        bus.cancel = 1'b0;
        run_muldiv(OP_MULT, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 34);
    endtask

    task automatic test_back_to_back();
        run_muldiv(OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0, 32'hFFFE_0001, 34);
        run_muldiv(OP_DIVU,  32'hFFFF_FFFF, 32'h10,        32'hF, 32'h0FFF_FFFF, 34);
        mf(OP_MFHI);
    endtask

    task automatic test_reset_mid();
        send(OP_DIVU, 32'd100, 32'd7);
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0;
        #2;
        model_hi = '0; model_lo = '0;
        checks++;
        if ({bus.op_ready, bus.busy, bus.rd_valid} !== 3'b100 || bus.hi_out !== 32'h0 ||
            bus.lo_out !== 32'h0 || bus.rd_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid rdy/busy/vld=%b%b%b hi=%h lo=%h rd=%h want 100/0/0/0",
                     bus.op_ready, bus.busy, bus.rd_valid, bus.hi_out, bus.lo_out, bus.rd_data);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (bus.busy !== 1'b0 || {bus.hi_out, bus.lo_out} !== 64'h0) begin
            failures++;
            $display("FAIL reset_mid_after busy=%b hilo=%h_%h want 0/0", bus.busy, bus.hi_out, bus.lo_out);
        end
    endtask

    initial begin
        bus.op_valid = 1'b0;
        bus.op_code  = OP_MFHI;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.cancel   = 1'b0;
        test_reset();
        test_mt_mf();
        test_mul();
        test_div();
        test_div0();
        test_hazard();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (hl_q.size() != 0 || rd_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain hl=%0d rd=%0d want 0/0", hl_q.size(), rd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
